fetch_queue: RTL and testbench

//  Instruction prefetch stage between imem and the pipeline's F/D latch. Streams sequential

---
 rtl/fetch_queue.sv | 163 ++++++++++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: streams sequential word addresses to imem and buffers the
// returned instructions with their PCs until the decode stage accepts them.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [31:0]                address_imem,
    input  logic [31:0]                q_imem,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [31:0]                deq_instr,
    output logic [31:0]                deq_pc,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   inflight_pc_r;
    logic          inflight_v_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] count_r;
    logic [31:0]   instr_mem_r [DEPTH];
    logic [31:0]   pc_mem_r [DEPTH];
    logic          head_valid_r;
    logic [31:0]   head_instr_r;
    logic [31:0]   head_pc_r;

    logic          issue_s;
    logic          wr_en_s;
    logic          pop_s;
    logic [LW:0]   credit_use_s;
    logic [31:0]   fetch_pc_nxt_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [LW-1:0] count_nxt_s;
    logic          head_valid_nxt_s;
    logic [31:0]   head_instr_nxt_s;
    logic [31:0]   head_pc_nxt_s;

    // Credit check, response write and handshake decode for the current cycle.
    always_comb begin
        credit_use_s = {1'b0, count_r} + {{LW{1'b0}}, inflight_v_r};
        issue_s      = !redirect && (credit_use_s < (LW+1)'(DEPTH));
        wr_en_s      = inflight_v_r && !redirect;
        pop_s        = head_valid_r && deq_ready && !redirect;
    end

    // Next fetch address, FIFO pointers and occupancy; redirect overrides everything.
    always_comb begin
        fetch_pc_nxt_s = fetch_pc_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        count_nxt_s    = count_r;
        if (redirect) begin
            fetch_pc_nxt_s = redirect_pc;
            wr_ptr_nxt_s   = {PW{1'b0}};
            rd_ptr_nxt_s   = {PW{1'b0}};
            count_nxt_s    = {LW{1'b0}};
        end else begin
            if (issue_s) begin
                fetch_pc_nxt_s = fetch_pc_r + 32'd1;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (wr_en_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_nxt_s = count_r + LW'(1);
                2'b01:   count_nxt_s = count_r - LW'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Next head entry; the slot being written this cycle bypasses storage when it becomes head.
    always_comb begin
        head_valid_nxt_s = (count_nxt_s != LW'(0));
        head_instr_nxt_s = 32'h0000_0000;
        head_pc_nxt_s    = 32'h0000_0000;
        if (!head_valid_nxt_s) begin
            head_instr_nxt_s = 32'h0000_0000;
            head_pc_nxt_s    = 32'h0000_0000;
        end else if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_instr_nxt_s = q_imem;
            head_pc_nxt_s    = inflight_pc_r;
        end else begin
            head_instr_nxt_s = instr_mem_r[rd_ptr_nxt_s];
            head_pc_nxt_s    = pc_mem_r[rd_ptr_nxt_s];
        end
    end

    // Control state and registered head outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_r    <= RESET_PC;
            inflight_v_r  <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            count_r       <= {LW{1'b0}};
            head_valid_r  <= 1'b0;
            head_instr_r  <= 32'h0000_0000;
            head_pc_r     <= 32'h0000_0000;
        end else begin
            fetch_pc_r    <= fetch_pc_nxt_s;
            inflight_v_r  <= issue_s;
            inflight_pc_r <= issue_s ? fetch_pc_r : inflight_pc_r;
            wr_ptr_r      <= wr_ptr_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            count_r       <= count_nxt_s;
            head_valid_r  <= head_valid_nxt_s;
            head_instr_r  <= head_instr_nxt_s;
            head_pc_r     <= head_pc_nxt_s;
        end
    end

    // FIFO storage; contents are don't-care until covered by count.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            instr_mem_r[wr_ptr_r] <= q_imem;
            pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
        end
    end

    assign address_imem = fetch_pc_r;
    assign deq_valid    = head_valid_r;
    assign deq_instr    = head_instr_r;
    assign deq_pc       = head_pc_r;
    assign level        = count_r;

    fetch_queue_chk #(.DEPTH(DEPTH), .LW(LW)) u_chk (
        .clock (clock),
        .reset (reset),
        .level (count_r)
    );
endmodule

// Occupancy bound checker for fetch_queue.
module fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input logic          clock,
    input logic          reset,
    input logic [LW-1:0] level
);
    count_bound_a: assert property (@(posedge clock) disable iff (!reset)
        ({1'b0, level} <= (LW+1)'(DEPTH)));
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based transaction model.
module tb_fetch_queue;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFE;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_imem;
    logic [31:0] q_imem = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        deq_ready = 1'b0;
    logic        deq_valid;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic [2:0]  level;

    logic [31:0] w_address_imem;
    logic [31:0] w_q_imem = 32'h0;
    logic        w_redirect = 1'b0;
    logic        w_deq_ready = 1'b1;
    logic        w_deq_valid;
    logic [31:0] w_deq_instr;
    logic [31:0] w_deq_pc;
    logic [2:0]  w_level;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mq_pc[$];
    logic [31:0] mq_in[$];
    bit          m_inf;
    logic [31:0] m_inf_pc;
    logic [31:0] m_fpc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
        .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
        .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc(deq_pc), .level(level)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
        .clock(clock), .reset(reset), .address_imem(w_address_imem), .q_imem(w_q_imem),
        .redirect(w_redirect), .redirect_pc(32'h0), .deq_ready(w_deq_ready),
        .deq_valid(w_deq_valid), .deq_instr(w_deq_instr), .deq_pc(w_deq_pc), .level(w_level)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    // imem: one-cycle read latency
    always @(posedge clock) begin
        q_imem   <= imem_f(address_imem);
        w_q_imem <= imem_f(w_address_imem);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_pc.delete();
        mq_in.delete();
        m_inf    = 1'b0;
        m_inf_pc = 32'h0;
        m_fpc    = 32'h0;
    endtask

    task automatic model_edge();
        int sz;
        bit pop, wr, iss;
        if (!reset) begin
            model_reset();
        end else if (redirect) begin
            mq_pc.delete();
            mq_in.delete();
            m_inf = 1'b0;
            m_fpc = redirect_pc;
        end else begin
            sz  = mq_pc.size();
            pop = (sz != 0) && deq_ready;
            wr  = m_inf;
            iss = (sz + int'(m_inf)) < DEPTH;
            if (pop) begin
                void'(mq_pc.pop_front());
                void'(mq_in.pop_front());
            end
            if (wr) begin
                mq_pc.push_back(m_inf_pc);
                mq_in.push_back(imem_f(m_inf_pc));
            end
            m_inf = iss;
            if (iss) begin
                m_inf_pc = m_fpc;
                m_fpc    = m_fpc + 32'd1;
            end
        end
    endtask

    task automatic compare_all();
        bit          e_v;
        logic [31:0] e_pc, e_in;
        e_v  = (mq_pc.size() != 0);
        e_pc = e_v ? mq_pc[0] : 32'h0;
        e_in = e_v ? mq_in[0] : 32'h0;
        check_val("address_imem", address_imem, m_fpc);
        check_val("deq_valid", {31'b0, deq_valid}, {31'b0, e_v});
        check_val("deq_pc", deq_pc, e_pc);
        check_val("deq_instr", deq_instr, e_in);
        check_val("level", {29'b0, level}, 32'(mq_pc.size()));
    endtask

    // Called at a negedge: drive inputs, advance one edge, check at the next negedge.
    task automatic step(input bit rdy, input bit rdr, input logic [31:0] rpc);
        deq_ready   = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        bit          r_rdy, r_rdr;
        logic [31:0] r_pc;
        model_reset();
        repeat (2) step(1'b1, 1'b0, 32'h0);

        // reset release and free-running stream
        reset = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        check_val("first_valid_cycle1", {31'b0, deq_valid}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check_val("first_valid_cycle2", {31'b0, deq_valid}, 32'h1);
        check_val("first_pc", deq_pc, 32'h0);
        check_val("first_instr", deq_instr, 32'h100);
        check_val("wrap_pc0", w_deq_pc, WRAP_PC);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 32'h0);
            check_val("stream_pc", deq_pc, 32'(k));
            check_val("wrap_pc", w_deq_pc, WRAP_PC + 32'(k));
            check_val("wrap_instr", w_deq_instr, imem_f(WRAP_PC + 32'(k)));
            check_val("wrap_valid", {31'b0, w_deq_valid}, 32'h1);
            check_val("wrap_level", {29'b0, w_level}, 32'h1);
        end

        // stall until full from pc 0
        step(1'b0, 1'b1, 32'h0);
        repeat (10) step(1'b0, 1'b0, 32'h0);
        check_val("stall_addr", address_imem, 32'h4);
        check_val("stall_level", {29'b0, level}, 32'h4);
        check_val("stall_head", deq_pc, 32'h0);

        // redirect while full; stale data must vanish
        step(1'b0, 1'b1, 32'h40);
        check_val("redir_level", {29'b0, level}, 32'h0);
        check_val("redir_addr", address_imem, 32'h40);
        step(1'b1, 1'b0, 32'h0);
        check_val("redir_n2_valid", {31'b0, deq_valid}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check_val("redir_n3_pc", deq_pc, 32'h40);
        check_val("redir_n3_valid", {31'b0, deq_valid}, 32'h1);

        // full queue drain, then redirect together with deq_ready
        repeat (6) step(1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h200);
        check_val("redir_pop_level", {29'b0, level}, 32'h0);

        // address wrap via redirect
        step(1'b1, 1'b1, 32'hFFFF_FFFD);
        repeat (8) step(1'b1, 1'b0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r_rdy = ($urandom_range(0, 9) < 7);
            r_rdr = ($urandom_range(0, 19) == 0);
            r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                                 : 32'($urandom);
            step(r_rdy, r_rdr, r_pc);
        end

        // asynchronous reset mid-stream
        step(1'b0, 1'b1, 32'h80);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        check_val("pre_reset_level", {29'b0, level}, 32'h3);
        #2 reset = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clock);
        step(1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        check_val("rst2_cycle1_valid", {31'b0, deq_valid}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check_val("rst2_cycle2_valid", {31'b0, deq_valid}, 32'h1);
        check_val("rst2_pc", deq_pc, 32'h0);
        repeat (4) step(1'b1, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
